// File: rtl/dot_frame_buf_pkg.sv
// Shared geometry and scroll-direction definitions for the dot-matrix frame buffer.
package dot_frame_buf_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ROW_W = 3;

  typedef enum logic {
    SCROLL_LEFT  = 1'b0,
    SCROLL_RIGHT = 1'b1
  } scroll_dir_e;

  function automatic logic [ROW_W-1:0] next_offset(input logic [ROW_W-1:0] off,
                                                   input scroll_dir_e dir);
    return (dir == SCROLL_RIGHT) ? off - 3'd1 : off + 3'd1;
  endfunction

endpackage

// File: rtl/dot_frame_buf_if.sv
// Writer, commit, scanner and scroll-control signals of the frame buffer.
interface dot_frame_buf_if;
  import dot_frame_buf_pkg::*;

  logic             wr_valid;
  logic             wr_ready;
  logic [ROW_W-1:0] wr_row;
  logic [COLS-1:0]  wr_data;
  logic             commit;
  logic             commit_pending;
  logic             frame_start;
  logic [ROW_W-1:0] scan_row;
  logic             scroll_en;
  logic             scroll_dir;
  logic [COLS-1:0]  col_data;

  modport slave (
    input  wr_valid, wr_row, wr_data, commit, frame_start, scan_row, scroll_en, scroll_dir,
    output wr_ready, commit_pending, col_data
  );

  modport master (
    output wr_valid, wr_row, wr_data, commit, frame_start, scan_row, scroll_en, scroll_dir,
    input  wr_ready, commit_pending, col_data
  );
endinterface

// File: rtl/dot_frame_buf_row_rotator.sv
// Combinational rotate-left of one row pattern: bit i moves to bit (i+amt) mod 8.
module dot_row_rotator
  import dot_frame_buf_pkg::*;
(
  input  logic [COLS-1:0]  row_i,
  input  logic [ROW_W-1:0] amt_i,
  output logic [COLS-1:0]  row_o
);

  always_comb begin
    row_o = '0;
    for (int i = 0; i < COLS; i++) begin
      row_o[i] = row_i[3'(i) - amt_i];
    end
  end

endmodule

// File: rtl/dot_frame_buf.sv
// Double-buffered 8x8 dot frame with frame-synchronous swap and horizontal scroll.
module dot_frame_buf
  import dot_frame_buf_pkg::*;
#(
  parameter int SCROLL_FRAMES = 16
) (
  input  logic           clk,
  input  logic           reset,
  dot_frame_buf_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(SCROLL_FRAMES - 1);

  logic [1:0][ROWS-1:0][COLS-1:0] frame_q, frame_d;
  logic                           fsel_q, fsel_d;
  logic                           pend_q, pend_d;
  logic [ROW_W-1:0]               off_q, off_d;
  logic [7:0]                     cnt_q, cnt_d;
  logic [COLS-1:0]                col_q, col_d;
  logic                           wr_fire;

  assign wr_fire            = bus.wr_valid && !pend_q;
  assign bus.wr_ready       = !pend_q;
  assign bus.commit_pending = pend_q;
  assign bus.col_data       = col_q;

  // Uses the pre-edge front and offset, so a swap shows up one cycle later.
  dot_row_rotator u_rot (
    .row_i (frame_q[fsel_q][bus.scan_row]),
    .amt_i (off_q),
    .row_o (col_d)
  );

  always_comb begin
    frame_d = frame_q;
    fsel_d  = fsel_q;
    pend_d  = pend_q;
    off_d   = off_q;
    cnt_d   = cnt_q;

    if (wr_fire) begin
      frame_d[~fsel_q][bus.wr_row] = bus.wr_data;
    end

    // A pending swap takes priority over any scroll step on the same frame.
    if (bus.frame_start && pend_q) begin
      fsel_d = ~fsel_q;
      pend_d = 1'b0;
      off_d  = '0;
      cnt_d  = '0;
    end else if (bus.frame_start && bus.scroll_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        off_d = next_offset(off_q, scroll_dir_e'(bus.scroll_dir));
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (bus.commit && !pend_q) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q <= '0;
      fsel_q  <= 1'b0;
      pend_q  <= 1'b0;
      off_q   <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
    end else begin
      frame_q <= frame_d;
      fsel_q  <= fsel_d;
      pend_q  <= pend_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: tb/tb_dot_frame_buf.sv
// Scoreboard bench for dot_frame_buf: a behavioural model predicts col_data per cycle.
module tb_dot_frame_buf;

  localparam int SF = 2;

  logic clk;
  logic reset;

  dot_frame_buf_if bus ();

  dot_frame_buf #(.SCROLL_FRAMES(SF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q [$];

  logic [7:0] m_buf [2][8];
  int         m_fsel;
  logic       m_pend;
  int         m_off;
  int         m_cnt;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
    logic [15:0] t;
    t = {x, x} << k;
    return t[15:8];
  endfunction

  task automatic m_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++)
        m_buf[b][r] = 8'h00;
    m_fsel = 0;
    m_pend = 1'b0;
    m_off  = 0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  // Called at posedge+1 with inputs already driven; advances one clock.
  task automatic tick();
    logic pend_old;
    logic [7:0] e;
    exp_q.push_back(rotl(m_buf[m_fsel][bus.scan_row], m_off));
    pend_old = m_pend;
    if (bus.wr_valid && !pend_old)
      m_buf[1 - m_fsel][bus.wr_row] = bus.wr_data;
    if (bus.frame_start && pend_old) begin
      m_fsel = 1 - m_fsel;
      m_pend = 1'b0;
      m_off  = 0;
      m_cnt  = 0;
    end else if (bus.frame_start && bus.scroll_en) begin
      if (m_cnt == SF - 1) begin
        m_cnt = 0;
        m_off = bus.scroll_dir ? (m_off + 7) % 8 : (m_off + 1) % 8;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (bus.commit && !pend_old) m_pend = 1'b1;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("col_data", bus.col_data, e);
    chk("commit_pending", {7'd0, bus.commit_pending}, {7'd0, m_pend});
    chk("wr_ready", {7'd0, bus.wr_ready}, {7'd0, !m_pend});
    bus.wr_valid    = 1'b0;
    bus.commit      = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic wr(input logic [2:0] row, input logic [7:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_row   = row;
    bus.wr_data  = data;
    tick();
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
  endtask

  task automatic fs();
    bus.frame_start = 1'b1;
    tick();
  endtask

  task automatic scan_all();
    for (int r = 0; r < 8; r++) begin
      bus.scan_row = 3'(r);
      tick();
    end
  endtask

  initial begin
    logic [7:0] pat [8];
    pat = '{8'h18, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42, 8'h42, 8'h7E};

    bus.wr_valid    = 1'b0;
    bus.wr_row      = 3'd0;
    bus.wr_data     = 8'h00;
    bus.commit      = 1'b0;
    bus.frame_start = 1'b0;
    bus.scan_row    = 3'd0;
    bus.scroll_en   = 1'b0;
    bus.scroll_dir  = 1'b0;
    reset = 1'b0;
    m_reset();
    #3;
    chk("rst_col", bus.col_data, 8'h00);
    chk("rst_pend", {7'd0, bus.commit_pending}, 8'h00);
    chk("rst_ready", {7'd0, bus.wr_ready}, 8'h01);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Load a pattern, commit and swap it in.
    for (int r = 0; r < 8; r++) wr(3'(r), pat[r]);
    do_commit();
    fs();
    chk("pend_cleared", {7'd0, bus.commit_pending}, 8'h00);
    bus.scan_row = 3'd3;
    tick();
    chk("row3_c3", bus.col_data, 8'hC3);
    scan_all();

    // Write while pending must be refused.
    do_commit();
    chk("ready_low", {7'd0, bus.wr_ready}, 8'h00);
    wr(3'd3, 8'hFF);
    scan_all();
    fs();
    bus.scan_row = 3'd3;
    tick();
    chk("refused_wr", bus.col_data, 8'h00);

    // Commit coinciding with frame_start only arms the swap.
    bus.commit = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    chk("same_cyc_pend", {7'd0, bus.commit_pending}, 8'h01);
    scan_all();
    fs();
    bus.scan_row = 3'd3;
    tick();
    chk("old_front_back", bus.col_data, 8'hC3);

    // Scroll left with SCROLL_FRAMES=2.
    wr(3'd0, 8'h81);
    do_commit();
    fs();
    bus.scan_row = 3'd0;
    bus.scroll_en = 1'b1;
    bus.scroll_dir = 1'b0;
    fs();
    fs();
    tick();
    chk("scroll_l1", bus.col_data, 8'h03);
    repeat (14) fs();
    tick();
    chk("scroll_wrap", bus.col_data, 8'h81);
    bus.scroll_en = 1'b0;
    repeat (3) fs();
    tick();
    chk("scroll_frozen", bus.col_data, 8'h81);

    // Scroll right from offset 0.
    wr(3'd0, 8'h01);
    do_commit();
    fs();
    bus.scroll_en = 1'b1;
    bus.scroll_dir = 1'b1;
    fs();
    fs();
    tick();
    chk("scroll_r7", bus.col_data, 8'h80);
    bus.scroll_en = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.wr_valid    = 1'($urandom_range(0, 1));
      bus.wr_row      = 3'($urandom_range(0, 7));
      bus.wr_data     = 8'($urandom_range(0, 255));
      bus.commit      = ($urandom_range(0, 7) == 0);
      bus.frame_start = ($urandom_range(0, 2) == 0);
      bus.scan_row    = 3'($urandom_range(0, 7));
      bus.scroll_en   = ($urandom_range(0, 3) != 0);
      bus.scroll_dir  = 1'($urandom_range(0, 1));
      tick();
    end
    bus.scroll_en = 1'b0;

    // Asynchronous reset while a swap is pending.
    if (m_pend == 1'b0) do_commit();
    bus.scan_row = 3'd0;
    #2 reset = 1'b0;
    #1;
    m_reset();
    chk("async_col", bus.col_data, 8'h00);
    chk("async_pend", {7'd0, bus.commit_pending}, 8'h00);
    chk("async_ready", {7'd0, bus.wr_ready}, 8'h01);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_pend", {7'd0, bus.commit_pending}, 8'h00);
    scan_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
